// File: rtl/rr_handshake_arbiter_mux.sv
`timescale 1ns/1ps
// Merges COUNT 4-phase req/ack channels onto one downstream link (round-robin or fixed priority) and captures the winner's payload.
// One cycle from an eligible request to req_out; a slow downstream ack just holds the FSM in REQ/REL.
module rr_handshake_arbiter_mux #(
  parameter int COUNT      = 5,
  parameter int COUNT_BITS = 3,
  parameter int DATA_WIDTH = 8,
  parameter int MODE       = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [COUNT-1:0]              reqs_in,
  output logic [COUNT-1:0]              acks_in,
  input  logic [COUNT*DATA_WIDTH-1:0]   data_in,
  input  logic [COUNT-1:0]              mask,
  output logic                          req_out,
  input  logic                          ack_out,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic [COUNT_BITS-1:0]         selected,
  output logic                          busy
);

  typedef enum logic [1:0] {IDLE, REQ, ACK, REL} state_t;

  state_t                  state, state_nxt;
  logic [COUNT_BITS-1:0]   ptr, ptr_nxt;
  logic [COUNT_BITS-1:0]   selected_nxt;
  logic [COUNT_BITS-1:0]   win_idx;
  logic                    win_vld;
  logic [COUNT-1:0]        eligible;
  logic [COUNT-1:0]        acks_nxt;
  logic [DATA_WIDTH-1:0]   data_nxt;
  logic                    req_nxt;
  logic                    busy_nxt;
  int                      cand;

  assign eligible = reqs_in & mask;

  // Scans run from lowest to highest priority so the last hit is the winner.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    if (MODE == 1) begin
      for (int i = COUNT - 1; i >= 0; i--) begin
        if (eligible[i]) begin
          win_vld = 1'b1;
          win_idx = COUNT_BITS'(i);
        end
      end
    end else begin
      for (int i = COUNT; i >= 1; i--) begin
        cand = int'(ptr) + i;
        if (cand >= COUNT) cand = cand - COUNT;
        if (eligible[cand]) begin
          win_vld = 1'b1;
          win_idx = COUNT_BITS'(cand);
        end
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    selected_nxt = selected;
    data_nxt     = data_out;
    req_nxt      = req_out;
    acks_nxt     = acks_in;
    busy_nxt     = busy;
    case (state)
      IDLE: begin
        if (win_vld) begin
          selected_nxt = win_idx;
          data_nxt     = data_in[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
          req_nxt      = 1'b1;
          busy_nxt     = 1'b1;
          state_nxt    = REQ;
        end
      end
      REQ: begin
        if (ack_out) begin
          acks_nxt           = '0;
          acks_nxt[selected] = 1'b1;
          state_nxt          = ACK;
        end
      end
      ACK: begin
        // The granted request is only looked at here; a drop during REQ is ignored.
        if (!reqs_in[selected]) begin
          req_nxt   = 1'b0;
          state_nxt = REL;
        end
      end
      REL: begin
        if (!ack_out) begin
          acks_nxt  = '0;
          busy_nxt  = 1'b0;
          ptr_nxt   = (MODE == 0) ? selected : ptr;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= COUNT_BITS'(COUNT - 1);
      selected <= '0;
      data_out <= '0;
      req_out  <= 1'b0;
      acks_in  <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      selected <= selected_nxt;
      data_out <= data_nxt;
      req_out  <= req_nxt;
      acks_in  <= acks_nxt;
      busy     <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_rr_handshake_arbiter_mux.sv
`timescale 1ns/1ps
// Directed bench: a round-robin instance (index 0) and a fixed-priority instance (index 1) driven by scripted clients.
module tb_rr_handshake_arbiter_mux;
  localparam int COUNT = 5;
  localparam int CB    = 3;
  localparam int DW    = 8;
  localparam logic [4:0] M = 5'b11111;
  localparam logic [4:0] N = 5'b10111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n;
  logic [COUNT-1:0]       reqs [2];
  logic [COUNT-1:0]       mask [2];
  logic [COUNT-1:0]       acks [2];
  logic                   ack_o [2];
  logic                   req_o [2];
  logic                   busy [2];
  logic [CB-1:0]          sel [2];
  logic [DW-1:0]          dout [2];
  logic [COUNT*DW-1:0]    din;

  int checks = 0;
  int errors = 0;

  rr_handshake_arbiter_mux #(.COUNT(COUNT), .COUNT_BITS(CB), .DATA_WIDTH(DW), .MODE(0)) u_rr (
    .clk(clk), .reset(rst_n), .reqs_in(reqs[0]), .acks_in(acks[0]), .data_in(din),
    .mask(mask[0]), .req_out(req_o[0]), .ack_out(ack_o[0]), .data_out(dout[0]),
    .selected(sel[0]), .busy(busy[0]));

  rr_handshake_arbiter_mux #(.COUNT(COUNT), .COUNT_BITS(CB), .DATA_WIDTH(DW), .MODE(1)) u_fp (
    .clk(clk), .reset(rst_n), .reqs_in(reqs[1]), .acks_in(acks[1]), .data_in(din),
    .mask(mask[1]), .req_out(req_o[1]), .ack_out(ack_o[1]), .data_out(dout[1]),
    .selected(sel[1]), .busy(busy[1]));

  typedef struct {
    logic [4:0] reqs;
    logic [4:0] mask;
    logic       ack;
    logic [7:0] d3;
    logic       e_req;
    logic [4:0] e_acks;
    logic [2:0] e_sel;
    logic       e_busy;
    logic [7:0] e_dat;
  } vec_t;

  vec_t vt [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cur(input int d, input int what);
    case (what)
      0:       return req_o[d];
      1:       return |acks[d];
      default: return busy[d];
    endcase
  endfunction

  task automatic wait_for(input int d, input int what, input logic val, input string name);
    int n;
    n = 0;
    while (cur(d, what) !== val && n < 50) begin
      tick();
      n++;
    end
    chk(name, 32'(cur(d, what)), 32'(val));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    reqs[0] = '0; reqs[1] = '0;
    ack_o[0] = 1'b0; ack_o[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Full 4-phase cycle as a well-behaved client; the winner re-raises its request afterwards.
  task automatic handshake(input int d, input int exp_ch, input string tag);
    int ch;
    wait_for(d, 0, 1'b1, {tag, " req_out rise"});
    chk({tag, " selected"}, 32'(sel[d]), exp_ch);
    chk({tag, " data_out"}, 32'(dout[d]), 32'(8'hA0 + exp_ch));
    ch = int'(sel[d]);
    ack_o[d] = 1'b1;
    wait_for(d, 1, 1'b1, {tag, " ack rise"});
    chk({tag, " acks onehot"}, 32'(acks[d]), 32'(1) << exp_ch);
    reqs[d][ch] = 1'b0;
    wait_for(d, 0, 1'b0, {tag, " req_out fall"});
    ack_o[d] = 1'b0;
    wait_for(d, 2, 1'b0, {tag, " busy fall"});
    chk({tag, " acks cleared"}, 32'(acks[d]), 0);
    reqs[d][ch] = 1'b1;
  endtask

  initial begin
    //          reqs      mask ack d3     | req acks      sel   busy  data
    vt[0]  = '{5'b00000, M, 1'b1, 8'hA3, 1'b0, 5'b00000, 3'd0, 1'b0, 8'h00};
    vt[1]  = '{5'b00100, M, 1'b0, 8'hA3, 1'b1, 5'b00000, 3'd2, 1'b1, 8'hA2};
    vt[2]  = '{5'b00100, M, 1'b0, 8'hA3, 1'b1, 5'b00000, 3'd2, 1'b1, 8'hA2};
    vt[3]  = '{5'b00100, M, 1'b1, 8'hA3, 1'b1, 5'b00100, 3'd2, 1'b1, 8'hA2};
    vt[4]  = '{5'b00100, M, 1'b1, 8'hA3, 1'b1, 5'b00100, 3'd2, 1'b1, 8'hA2};
    vt[5]  = '{5'b00000, M, 1'b1, 8'hA3, 1'b0, 5'b00100, 3'd2, 1'b1, 8'hA2};
    vt[6]  = '{5'b00000, M, 1'b1, 8'hA3, 1'b0, 5'b00100, 3'd2, 1'b1, 8'hA2};
    vt[7]  = '{5'b00000, M, 1'b0, 8'hA3, 1'b0, 5'b00000, 3'd2, 1'b0, 8'hA2};
    vt[8]  = '{5'b11111, M, 1'b0, 8'hA3, 1'b1, 5'b00000, 3'd3, 1'b1, 8'hA3};
    vt[9]  = '{5'b11111, M, 1'b1, 8'hA3, 1'b1, 5'b01000, 3'd3, 1'b1, 8'hA3};
    vt[10] = '{5'b11111, N, 1'b1, 8'h55, 1'b1, 5'b01000, 3'd3, 1'b1, 8'hA3};
    vt[11] = '{5'b10111, N, 1'b1, 8'h55, 1'b0, 5'b01000, 3'd3, 1'b1, 8'hA3};
    vt[12] = '{5'b10111, N, 1'b0, 8'h55, 1'b0, 5'b00000, 3'd3, 1'b0, 8'hA3};
    vt[13] = '{5'b10111, N, 1'b0, 8'h55, 1'b1, 5'b00000, 3'd4, 1'b1, 8'hA4};
    vt[14] = '{5'b10111, N, 1'b1, 8'h55, 1'b1, 5'b10000, 3'd4, 1'b1, 8'hA4};
    vt[15] = '{5'b00111, N, 1'b1, 8'h55, 1'b0, 5'b10000, 3'd4, 1'b1, 8'hA4};
    vt[16] = '{5'b00111, N, 1'b0, 8'hA3, 1'b0, 5'b00000, 3'd4, 1'b0, 8'hA4};
    vt[17] = '{5'b00111, M, 1'b0, 8'hA3, 1'b1, 5'b00000, 3'd0, 1'b1, 8'hA0};
    vt[18] = '{5'b00110, M, 1'b0, 8'hA3, 1'b1, 5'b00000, 3'd0, 1'b1, 8'hA0};
    vt[19] = '{5'b00110, M, 1'b1, 8'hA3, 1'b1, 5'b00001, 3'd0, 1'b1, 8'hA0};
    vt[20] = '{5'b00110, M, 1'b1, 8'hA3, 1'b0, 5'b00001, 3'd0, 1'b1, 8'hA0};
    vt[21] = '{5'b00110, M, 1'b0, 8'hA3, 1'b0, 5'b00000, 3'd0, 1'b0, 8'hA0};

    for (int k = 0; k < COUNT; k++) din[k*DW +: DW] = DW'(8'hA0 + k);
    rst_n = 1'b0;
    reqs[0] = 5'b11111; reqs[1] = 5'b11111;
    mask[0] = M; mask[1] = M;
    ack_o[0] = 1'b0; ack_o[1] = 1'b0;

    // Reset state with every request raised
    #12;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset%0d req_out", d), 32'(req_o[d]), 0);
      chk($sformatf("reset%0d acks", d), 32'(acks[d]), 0);
      chk($sformatf("reset%0d busy", d), 32'(busy[d]), 0);
      chk($sformatf("reset%0d selected", d), 32'(sel[d]), 0);
      chk($sformatf("reset%0d data_out", d), 32'(dout[d]), 0);
    end
    @(negedge clk);
    reqs[0] = '0; reqs[1] = '0; mask[1] = '0;
    rst_n = 1'b1;

    // Scripted handshakes on the round-robin instance
    for (int i = 0; i < 22; i++) begin
      reqs[0]  = vt[i].reqs;
      mask[0]  = vt[i].mask;
      ack_o[0] = vt[i].ack;
      din[3*DW +: DW] = vt[i].d3;
      tick();
      chk($sformatf("v%0d req_out", i), 32'(req_o[0]), 32'(vt[i].e_req));
      chk($sformatf("v%0d acks", i), 32'(acks[0]), 32'(vt[i].e_acks));
      chk($sformatf("v%0d selected", i), 32'(sel[0]), 32'(vt[i].e_sel));
      chk($sformatf("v%0d busy", i), 32'(busy[0]), 32'(vt[i].e_busy));
      chk($sformatf("v%0d data_out", i), 32'(dout[0]), 32'(vt[i].e_dat));
    end

    // Round-robin fairness with all clients saturating, including wrap
    do_reset();
    mask[0] = M;
    reqs[0] = 5'b11111;
    for (int k = 0; k <= COUNT; k++) handshake(0, k % COUNT, $sformatf("rr%0d", k));

    // Fixed priority: channel 1 always wins until masked off
    do_reset();
    mask[1] = M;
    reqs[1] = 5'b10110;
    for (int k = 0; k < 3; k++) handshake(1, 1, $sformatf("fp%0d", k));
    mask[1] = 5'b11101;
    handshake(1, 2, "fp_masked");

    // Asynchronous reset in REL with acks_in[1] high
    do_reset();
    mask[0] = M;
    reqs[0] = 5'b00010;
    tick();
    chk("ar grant req_out", 32'(req_o[0]), 1);
    chk("ar grant selected", 32'(sel[0]), 1);
    ack_o[0] = 1'b1;
    tick();
    chk("ar acks", 32'(acks[0]), 32'(5'b00010));
    reqs[0] = '0;
    tick();
    chk("ar in REL req_out", 32'(req_o[0]), 0);
    chk("ar in REL acks", 32'(acks[0]), 32'(5'b00010));
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar async acks", 32'(acks[0]), 0);
    chk("ar async req_out", 32'(req_o[0]), 0);
    chk("ar async busy", 32'(busy[0]), 0);
    reqs[0] = 5'b00010;
    ack_o[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ar restart req_out", 32'(req_o[0]), 1);
    chk("ar restart selected", 32'(sel[0]), 1);
    chk("ar restart busy", 32'(busy[0]), 1);

    // Slow downstream, then everything masked off
    do_reset();
    mask[0] = M;
    reqs[0] = 5'b00001;
    tick();
    chk("slow grant", 32'(req_o[0]), 1);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("slow hold%0d req_out", k), 32'(req_o[0]), 1);
      chk($sformatf("slow hold%0d acks", k), 32'(acks[0]), 0);
    end
    ack_o[0] = 1'b1;
    tick();
    chk("slow acks", 32'(acks[0]), 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("slow ack%0d acks", k), 32'(acks[0]), 1);
      chk($sformatf("slow ack%0d req_out", k), 32'(req_o[0]), 1);
    end
    reqs[0] = '0;
    tick();
    chk("slow release req_out", 32'(req_o[0]), 0);
    ack_o[0] = 1'b0;
    tick();
    chk("slow done busy", 32'(busy[0]), 0);
    chk("slow done acks", 32'(acks[0]), 0);
    mask[0] = '0;
    reqs[0] = 5'b11111;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("masked%0d busy/req", k), 32'({busy[0], req_o[0]}), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
